// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port 4x4 SRAM.
// Each accepted request runs IDLE -> ACCESS -> RESP: the grant is shown in
// ACCESS, the completion pulse in RESP, and read data is captured at the
// ACCESS->RESP edge. Every SRAM control output comes straight from a flop,
// so the SRAM never sees a glitch on its operation line.
module sram_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       we_a,
    input  logic       we_b,
    input  logic [1:0] addr_a,
    input  logic [1:0] addr_b,
    input  logic [3:0] wdata_a,
    input  logic [3:0] wdata_b,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       done_a,
    output logic       done_b,
    output logic [3:0] rdata_a,
    output logic [3:0] rdata_b,
    output logic       busy,
    output logic [1:0] mem_select,
    output logic       mem_operation,
    output logic       mem_enable,
    output logic [3:0] mem_data_in,
    input  logic [3:0] mem_data_out
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t     r_state;
    logic       r_last_b;      // 1 = port B won the most recent arbitration
    logic       r_win_b;       // winner of the transaction in flight
    logic       r_we;
    logic [1:0] r_addr;
    logic [3:0] r_wdata;
    logic       r_gnt_a;
    logic       r_gnt_b;
    logic       r_done_a;
    logic       r_done_b;
    logic [3:0] r_rdata_a;
    logic [3:0] r_rdata_b;
    logic       r_busy;
    logic       r_mem_enable;
    logic       r_mem_operation;

    logic       w_any_req;
    logic       w_pick_b;
    logic       w_we;
    logic [1:0] w_addr;
    logic [3:0] w_wdata;

    // On a tie, B wins only if A won last; a lone requester always wins.
    assign w_any_req = req_a | req_b;
    assign w_pick_b  = req_b & (~req_a | ~r_last_b);
    assign w_we      = w_pick_b ? we_b    : we_a;
    assign w_addr    = w_pick_b ? addr_b  : addr_a;
    assign w_wdata   = w_pick_b ? wdata_b : wdata_a;

    // Arbitration FSM with all outputs registered one state ahead.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_last_b        <= 1'b1;
            r_win_b         <= 1'b0;
            r_we            <= 1'b0;
            r_addr          <= 2'd0;
            r_wdata         <= 4'd0;
            r_gnt_a         <= 1'b0;
            r_gnt_b         <= 1'b0;
            r_done_a        <= 1'b0;
            r_done_b        <= 1'b0;
            r_rdata_a       <= 4'd0;
            r_rdata_b       <= 4'd0;
            r_busy          <= 1'b0;
            r_mem_enable    <= 1'b0;
            r_mem_operation <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state         <= S_ACCESS;
                        r_win_b         <= w_pick_b;
                        r_last_b        <= w_pick_b;
                        r_we            <= w_we;
                        r_addr          <= w_addr;
                        r_wdata         <= w_wdata;
                        r_gnt_a         <= ~w_pick_b;
                        r_gnt_b         <= w_pick_b;
                        r_busy          <= 1'b1;
                        r_mem_enable    <= 1'b1;
                        r_mem_operation <= ~w_we;
                    end
                end
                S_ACCESS: begin
                    r_state         <= S_RESP;
                    r_gnt_a         <= 1'b0;
                    r_gnt_b         <= 1'b0;
                    r_mem_enable    <= 1'b0;
                    r_mem_operation <= 1'b1;
                    r_done_a        <= ~r_win_b;
                    r_done_b        <= r_win_b;
                    if (!r_we) begin
                        if (r_win_b) begin
                            r_rdata_b <= mem_data_out;
                        end else begin
                            r_rdata_a <= mem_data_out;
                        end
                    end
                end
                S_RESP: begin
                    r_state  <= S_IDLE;
                    r_done_a <= 1'b0;
                    r_done_b <= 1'b0;
                    r_busy   <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Select and data lines simply reflect the latched command, so they hold
    // their last value outside ACCESS.
    assign gnt_a         = r_gnt_a;
    assign gnt_b         = r_gnt_b;
    assign done_a        = r_done_a;
    assign done_b        = r_done_b;
    assign rdata_a       = r_rdata_a;
    assign rdata_b       = r_rdata_b;
    assign busy          = r_busy;
    assign mem_select    = r_addr;
    assign mem_data_in   = r_wdata;
    assign mem_enable    = r_mem_enable;
    assign mem_operation = r_mem_operation;

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-002 The ports SHALL be as listed below, clock and reset first:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- req_a / req_b  in  1  access request, port A / B
- we_a / we_b  in  1  1 = write, 0 = read
- addr_a / addr_b  in  2  word select 0..3
- wdata_a / wdata_b  in  4  write data
- gnt_a / gnt_b  out  1  one-cycle grant pulse
- done_a / done_b  out  1  one-cycle completion pulse
- rdata_a / rdata_b  out  4  read data, valid when the matching done is high on a read
- busy  out  1  high whenever the state is not IDLE
- mem_select  out  2  to SRAM select
- mem_operation  out  1  to SRAM operation: 0 = write, 1 = read
- mem_enable  out  1  to SRAM enable
- mem_data_in  out  4  to SRAM data_in
- mem_data_out  in  4  from SRAM data_out (combinational)

Function
REQ-003 The FSM SHALL have three states: IDLE, ACCESS, RESP. Encoding is free.
REQ-004 In IDLE with no request, the FSM SHALL stay in IDLE.
REQ-005 In IDLE with any req_x high at a clock edge, the FSM SHALL:
- latch the winner's we, addr and wdata into command registers;
- latch the winner ID;
- go to ACCESS.
REQ-006 Arbitration SHALL be round-robin using a last-winner pointer:
- a single requester always wins;
- if both request, the port that did not win last wins;
- the pointer updates only when a request is accepted.
REQ-007 In ACCESS, the block SHALL:
- hold gnt_x of the winner high for exactly that cycle;
- drive mem_enable = 1;
- drive mem_select = latched addr;
- drive mem_data_in = latched wdata;
- drive mem_operation = 0 for a write, 1 for a read.
REQ-008 ACCESS SHALL last exactly one cycle and then go to RESP. On a read, mem_data_out SHALL be registered into rdata_x of the winner at the ACCESS→RESP edge.
REQ-009 In RESP, the block SHALL hold done_x of the winner high for exactly one cycle and then return to IDLE. Back-to-back throughput is one transaction per 3 cycles.
REQ-010 Latency from the req sample edge:
- gnt_x is high in cycle N+1;
- done_x is high in cycle N+2;
- rdata_x is valid from cycle N+2.
REQ-011 rdata_x SHALL hold its last value until the next read completes on the same port. Writes SHALL NOT alter rdata_x.
REQ-012 Outside ACCESS, the block SHALL drive:
- mem_enable = 0;
- mem_operation = 1, because the SRAM writes whenever operation is 0;
- mem_select and mem_data_in holding their last value.
REQ-013 mem_operation SHALL be 0 only in the ACCESS cycle of a write, and SHALL be glitch-free (a registered output).
REQ-014 req, we, addr and wdata SHALL be sampled only in IDLE; changes during ACCESS or RESP SHALL be ignored.
REQ-015 A requester SHALL hold req and its command stable until gnt. A req still high in the RESP cycle competes again at the following IDLE edge.
REQ-016 gnt_a/gnt_b SHALL never be high together. done_a/done_b SHALL never be high together.
REQ-017 busy SHALL be high in ACCESS and RESP, and low in IDLE.

Reset
REQ-018 When rst is high at a clock edge, at the next cycle the block SHALL be in IDLE with:
- gnt_*, done_*, busy, mem_enable = 0;
- mem_operation = 1;
- mem_select = 0, mem_data_in = 0;
- rdata_a = rdata_b = 0;
- last-winner pointer = B, so A wins the first tie.
REQ-019 A reset asserted during ACCESS or RESP SHALL abort the transaction:
- no done pulse afterwards;
- no write after the reset edge, because mem_operation returns to 1;
- no rdata update.
REQ-020 rst SHALL take priority over all other inputs.

Verification
REQ-021 Single write then read: A write addr=2 wdata=0xA; then A read addr=2 → gnt_a at N+1, done_a at N+2, rdata_a=0xA; rdata_b stays 0.
REQ-022 Tie after reset: req_a=req_b=1 held → grant order A,B,A,B. A write 0x3 to addr1, then B read addr1 → rdata_b=0x3.
REQ-023 Write-protection check: in every non-ACCESS cycle, assert mem_operation==1 and mem_enable==0. After a stream of reads over addrs 0..3, SRAM contents are unchanged.
REQ-024 Command change after sampling: req_b write addr0 0x5; change wdata_b to 0xF in cycle N+1 → SRAM addr0 = 0x5.
REQ-025 Reset mid-transaction: start an A write of 0xC to addr3 (previously 0x6); assert rst in the IDLE→ACCESS cycle so it is sampled at the ACCESS edge → no done_a; mem_operation=1 the next cycle; busy=0; all outputs at reset values.
REQ-026 Single requester: B alone issues 4 consecutive reads (req_b held) → every grant goes to B, done_b at a 3-cycle period, gnt_a never high.
